output_sequencer: RTL and testbench

- Buffers DEPTH result words, then presents them one at a time on Data_Out.
- Paces the presentation with a programmable strobe.
- Directly drives the downstream output counter through En_Count, Show_DATA and NEW_OUTPUT.
- Uses the counter's Count as its read index and its Done_Flag as end-of-sequence, then holds until cleared.

---
 rtl/output_sequencer.sv | 113 +++++++++++
 tb/tb_output_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_sequencer.sv
// Buffers DEPTH result words, then presents them one per PACE-cycle strobe, indexed by the downstream counter.
// Latency: Start to SHOW in 1 cycle, first NEW_OUTPUT PACE cycles later; writes are accepted only while IDLE and not full.
module output_sequencer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 9,
  parameter int PACE   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Load_Valid,
  input  logic [DATA_W-1:0] Load_Data,
  output logic              Load_Ready,
  input  logic              Start,
  input  logic              Clear,
  input  logic [3:0]        Count,
  input  logic              Done_Flag,
  output logic              En_Count,
  output logic              Show_DATA,
  output logic              NEW_OUTPUT,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Busy,
  output logic              Seq_Done
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (PACE > 2) ? $clog2(PACE) : 1;
  localparam logic [PW-1:0] FULL    = PW'(DEPTH);
  localparam logic [3:0]    DEPTH_C = 4'(DEPTH);
  localparam logic [TW-1:0] RELOAD  = TW'(PACE - 1);

  typedef enum logic [1:0] {IDLE, SHOW, FINISH} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              new_output_d;
  logic              wr_en;
  logic [DATA_W-1:0] buf_q [DEPTH];

  assign Load_Ready = (state_q == IDLE) && (wr_ptr_q < FULL);

  // Read is gated so a Count past the last word never indexes the buffer.
  assign Data_Out = ((state_q == SHOW) && (Count < DEPTH_C)) ? buf_q[Count[AW-1:0]] : '0;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    timer_d      = timer_q;
    new_output_d = 1'b0;
    wr_en        = 1'b0;
    if (Clear) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      timer_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Load_Valid && Load_Ready) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
          // Fullness is judged on the registered pointer, so a same-cycle last write does not count.
          if (Start && (wr_ptr_q == FULL)) begin
            state_d = SHOW;
            timer_d = RELOAD;
          end
        end
        SHOW: begin
          if (Done_Flag) begin
            state_d = FINISH;
          end else if (timer_q == '0) begin
            new_output_d = 1'b1;
            timer_d      = RELOAD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        FINISH: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      timer_q    <= '0;
      En_Count   <= 1'b0;
      Show_DATA  <= 1'b0;
      NEW_OUTPUT <= 1'b0;
      Busy       <= 1'b0;
      Seq_Done   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      timer_q    <= timer_d;
      En_Count   <= (state_d != IDLE);
      Show_DATA  <= (state_d == SHOW);
      NEW_OUTPUT <= new_output_d;
      Busy       <= (state_d != IDLE);
      Seq_Done   <= (state_d == FINISH);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      buf_q[wr_ptr_q[AW-1:0]] <= Load_Data;
    end
  end

endmodule

// File: tb/tb_output_sequencer.sv
// Directed bench: two sequencers (PACE=4 and PACE=2) share stimulus, each paired with a downstream counter model.
module tb_output_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       start = 1'b0;
  logic       clear = 1'b0;

  logic       ready_a, en_a, show_a, new_a, busy_a, sdone_a, done_a;
  logic [7:0] data_a;
  logic [3:0] cnt_a;
  logic       ready_b, en_b, show_b, new_b, busy_b, sdone_b, done_b;
  logic [7:0] data_b;
  logic [3:0] cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_sequencer #(.DATA_W(8), .DEPTH(9), .PACE(4)) dut (
    .CLK(clk), .RST(rst_n), .Load_Valid(load_valid), .Load_Data(load_data),
    .Load_Ready(ready_a), .Start(start), .Clear(clear), .Count(cnt_a),
    .Done_Flag(done_a), .En_Count(en_a), .Show_DATA(show_a), .NEW_OUTPUT(new_a),
    .Data_Out(data_a), .Busy(busy_a), .Seq_Done(sdone_a)
  );

  output_sequencer #(.DATA_W(8), .DEPTH(9), .PACE(2)) dut2 (
    .CLK(clk), .RST(rst_n), .Load_Valid(load_valid), .Load_Data(load_data),
    .Load_Ready(ready_b), .Start(start), .Clear(clear), .Count(cnt_b),
    .Done_Flag(done_b), .En_Count(en_b), .Show_DATA(show_b), .NEW_OUTPUT(new_b),
    .Data_Out(data_b), .Busy(busy_b), .Seq_Done(sdone_b)
  );

  // Downstream counter: cleared while disabled, advances on each strobe, saturates at its Done threshold of 9.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt_a <= 4'd0;
    else if (!en_a)                   cnt_a <= 4'd0;
    else if (new_a && cnt_a != 4'd9)  cnt_a <= cnt_a + 4'd1;
  end
  assign done_a = (cnt_a == 4'd9);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt_b <= 4'd0;
    else if (!en_b)                   cnt_b <= 4'd0;
    else if (new_b && cnt_b != 4'd9)  cnt_b <= cnt_b + 4'd1;
  end
  assign done_b = (cnt_b == 4'd9);

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] d);
    load_valid = 1'b1;
    load_data  = d;
    cycle();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    checks++;
    if ({ready_a, en_a, show_a, new_a, busy_a, sdone_a} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags_a: got %b want 100000", {ready_a, en_a, show_a, new_a, busy_a, sdone_a});
    end
    checks++;
    if ({ready_b, en_b, show_b, new_b, busy_b, sdone_b} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags_b: got %b want 100000", {ready_b, en_b, show_b, new_b, busy_b, sdone_b});
    end
    checks++;
    if (data_a !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h want 00", data_a);
    end
    load_word(8'h11);
    load_word(8'h22);
    load_word(8'h33);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready_a, busy_a, en_a} !== 3'b100) begin
      errors++;
      $display("FAIL reset_midfill: got %b want 100", {ready_a, busy_a, en_a});
    end
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_fill_and_early_start();
    for (int i = 1; i <= 5; i++) load_word(8'(i * 8'h11));
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    checks++;
    if ({busy_a, en_a, show_a} !== 3'b000) begin
      errors++;
      $display("FAIL early_start: got busy/en/show %b want 000", {busy_a, en_a, show_a});
    end
    for (int i = 6; i <= 8; i++) load_word(8'(i * 8'h11));
    checks++;
    if (ready_a !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_8: got %b want 1", ready_a);
    end
    start = 1'b1;
    load_word(8'h99);
    start = 1'b0;
    checks++;
    if ({ready_a, busy_a} !== 2'b00) begin
      errors++;
      $display("FAIL last_write_with_start: got ready/busy %b want 00", {ready_a, busy_a});
    end
    load_word(8'hEE);
    checks++;
    if ({ready_a, busy_a} !== 2'b00) begin
      errors++;
      $display("FAIL write_when_full: got ready/busy %b want 00", {ready_a, busy_a});
    end
  endtask

  task automatic test_full_sequence(input logic [7:0] base, input logic [7:0] step);
    int na = 0;
    int nb = 0;
    logic [7:0] expv;
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      cycle();
      if (c == 1) begin
        start = 1'b0;
        checks++;
        if ({busy_a, show_a, en_a, new_a} !== 4'b1110) begin
          errors++;
          $display("FAIL enter_show: got busy/show/en/new %b want 1110", {busy_a, show_a, en_a, new_a});
        end
      end
      if (new_a) begin
        checks++;
        if (c != 1 + 4 * (na + 1)) begin
          errors++;
          $display("FAIL strobe_time_a: strobe %0d at cycle %0d want %0d", na, c, 1 + 4 * (na + 1));
        end
        expv = base + step * 8'(na);
        checks++;
        if (data_a !== expv) begin
          errors++;
          $display("FAIL data_a: strobe %0d got %h want %h", na, data_a, expv);
        end
        na++;
      end
      if (new_b) begin
        checks++;
        if (c != 1 + 2 * (nb + 1)) begin
          errors++;
          $display("FAIL strobe_time_b: strobe %0d at cycle %0d want %0d", nb, c, 1 + 2 * (nb + 1));
        end
        expv = base + step * 8'(nb);
        checks++;
        if (data_b !== expv) begin
          errors++;
          $display("FAIL data_b: strobe %0d got %h want %h", nb, data_b, expv);
        end
        nb++;
      end
      if (show_a && cnt_a >= 4'd9) begin
        checks++;
        if (data_a !== 8'h00) begin
          errors++;
          $display("FAIL data_out_of_range: got %h want 00", data_a);
        end
      end
      if (sdone_a && sdone_b) break;
    end
    checks++;
    if (na != 9 || nb != 9) begin
      errors++;
      $display("FAIL strobe_count: got a=%0d b=%0d want 9 each", na, nb);
    end
    checks++;
    if ({sdone_a, show_a, busy_a, en_a, sdone_b} !== 5'b10111) begin
      errors++;
      $display("FAIL finish_flags: got %b want 10111", {sdone_a, show_a, busy_a, en_a, sdone_b});
    end
    checks++;
    if (cnt_a !== 4'd9 || data_a !== 8'h00) begin
      errors++;
      $display("FAIL finish_count: got count %0d data %h want 9 00", cnt_a, data_a);
    end
    start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      checks++;
      if ({new_a, new_b, sdone_a, sdone_b} !== 4'b0011) begin
        errors++;
        $display("FAIL finish_hold: got new_a/new_b/done_a/done_b %b want 0011", {new_a, new_b, sdone_a, sdone_b});
      end
    end
    start = 1'b0;
  endtask

  task automatic test_clear_after_done();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    checks++;
    if ({ready_a, busy_a, en_a, show_a, sdone_a} !== 5'b10000) begin
      errors++;
      $display("FAIL clear_done: got ready/busy/en/show/done %b want 10000", {ready_a, busy_a, en_a, show_a, sdone_a});
    end
    cycle();
    checks++;
    if (cnt_a !== 4'd0 || cnt_b !== 4'd0) begin
      errors++;
      $display("FAIL clear_count: got a=%0d b=%0d want 0", cnt_a, cnt_b);
    end
    for (int i = 1; i <= 8; i++) load_word(8'(8'hA0 + i));
    checks++;
    if (ready_a !== 1'b1) begin
      errors++;
      $display("FAIL reload_ptr: ready after 8 writes got %b want 1", ready_a);
    end
    load_word(8'hA9);
    checks++;
    if (ready_a !== 1'b0) begin
      errors++;
      $display("FAIL reload_full: ready after 9 writes got %b want 0", ready_a);
    end
  endtask

  task automatic test_abort();
    int na = 0;
    logic bad = 1'b0;
    for (int i = 1; i <= 9; i++) load_word(8'(i * 8'h11));
    start = 1'b1;
    for (int c = 1; c <= 40 && na < 3; c++) begin
      cycle();
      start = 1'b0;
      if (new_a) na++;
    end
    checks++;
    if (na != 3) begin
      errors++;
      $display("FAIL abort_reach: got %0d strobes want 3", na);
    end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    checks++;
    if ({busy_a, show_a, en_a, sdone_a} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle: got busy/show/en/done %b want 0000", {busy_a, show_a, en_a, sdone_a});
    end
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (new_a || sdone_a || new_b || sdone_b) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: got activity %b want 0", bad);
    end
  endtask

  task automatic test_reset_mid_show();
    for (int i = 1; i <= 9; i++) load_word(8'(i * 8'h11));
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 5; c++) cycle();
    checks++;
    if ({busy_a, show_a} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_show: got busy/show %b want 11", {busy_a, show_a});
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready_a, en_a, show_a, new_a, busy_a, sdone_a} !== 6'b100000 || data_a !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got %b data %h want 100000 data 00", {ready_a, en_a, show_a, new_a, busy_a, sdone_a}, data_a);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_clear_with_load();
    clear      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h5A;
    cycle();
    clear      = 1'b0;
    load_valid = 1'b0;
    for (int i = 1; i <= 8; i++) load_word(8'(i));
    checks++;
    if (ready_a !== 1'b1) begin
      errors++;
      $display("FAIL clear_load_ptr: ready after 8 writes got %b want 1", ready_a);
    end
    load_word(8'h09);
    checks++;
    if (ready_a !== 1'b0) begin
      errors++;
      $display("FAIL clear_load_full: ready after 9 writes got %b want 0", ready_a);
    end
  endtask

  initial begin
    test_reset();
    test_fill_and_early_start();
    test_full_sequence(8'h11, 8'h11);
    test_clear_after_done();
    test_full_sequence(8'hA1, 8'h01);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    test_abort();
    test_reset_mid_show();
    test_clear_with_load();
    test_full_sequence(8'h01, 8'h01);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
